// File: rtl/taxi_eth_tx_sched_pkg.sv
// taxi_eth_tx_sched_pkg: shared state encoding and tag-field helper for the TX scheduler.
package taxi_eth_tx_sched_pkg;

    typedef enum logic {
        STATE_IDLE = 1'b0,
        STATE_XFER = 1'b1
    } state_t;

    // LSB of the port-index field that sits at the top of the MAC-side tag
    function automatic int port_lsb(input int tx_tag_w, input int ports);
        return tx_tag_w - $clog2(ports);
    endfunction

endpackage

// File: rtl/taxi_arb_rr.sv
// taxi_arb_rr: combinational round-robin picker; first request at or above i_ptr, wrapping.
module taxi_arb_rr #(
    parameter int N  = 4,
    parameter int CL = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [CL-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic [CL-1:0] o_idx,
    output logic          o_valid
);

    always_comb begin
        o_idx   = '0;
        o_valid = 1'b0;
        // scan downward so the lowest offset from the pointer wins
        for (int i = N - 1; i >= 0; i--) begin
            if (i_req[(int'(i_ptr) + i) % N]) begin
                o_idx   = CL'((int'(i_ptr) + i) % N);
                o_valid = 1'b1;
            end
        end
        o_gnt = o_valid ? (N'(1) << o_idx) : '0;
    end

endmodule

// File: rtl/taxi_eth_tx_sched.sv
// taxi_eth_tx_sched: per-frame round-robin sharing of one MAC TX port, with completion
// routing back to the source port and a per-port limit on frames awaiting completion.
module taxi_eth_tx_sched
    import taxi_eth_tx_sched_pkg::*;
#(
    parameter int PORTS           = 4,
    parameter int DATA_W          = 32,
    parameter int USER_W          = 1,
    parameter int PTP_TS_W        = 96,
    parameter int TX_TAG_W        = 16,
    parameter int CL_PORTS        = $clog2(PORTS),
    parameter int IN_TAG_W        = TX_TAG_W - CL_PORTS,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [PORTS-1:0][DATA_W-1:0]        s_axis_tx_tdata,
    input  logic [PORTS-1:0][DATA_W/8-1:0]      s_axis_tx_tkeep,
    input  logic [PORTS-1:0]                    s_axis_tx_tlast,
    input  logic [PORTS-1:0][USER_W-1:0]        s_axis_tx_tuser,
    input  logic [PORTS-1:0][IN_TAG_W-1:0]      s_axis_tx_tid,
    input  logic [PORTS-1:0]                    s_axis_tx_tvalid,
    output logic [PORTS-1:0]                    s_axis_tx_tready,
    output logic [DATA_W-1:0]                   m_axis_tx_tdata,
    output logic [DATA_W/8-1:0]                 m_axis_tx_tkeep,
    output logic                                m_axis_tx_tlast,
    output logic [USER_W-1:0]                   m_axis_tx_tuser,
    output logic [TX_TAG_W-1:0]                 m_axis_tx_tid,
    output logic                                m_axis_tx_tvalid,
    input  logic                                m_axis_tx_tready,
    input  logic [PTP_TS_W-1:0]                 s_axis_tx_cpl_tdata,
    input  logic [TX_TAG_W-1:0]                 s_axis_tx_cpl_tid,
    input  logic                                s_axis_tx_cpl_tvalid,
    output logic                                s_axis_tx_cpl_tready,
    output logic [PORTS-1:0][PTP_TS_W-1:0]      m_axis_tx_cpl_tdata,
    output logic [PORTS-1:0][IN_TAG_W-1:0]      m_axis_tx_cpl_tid,
    output logic [PORTS-1:0]                    m_axis_tx_cpl_tvalid,
    input  logic [PORTS-1:0]                    m_axis_tx_cpl_tready,
    input  logic [PORTS-1:0]                    cfg_port_enable,
    output logic [PORTS-1:0]                    status_grant,
    output logic [PORTS-1:0]                    status_outstanding_full,
    output logic                                stat_cpl_drop
);

    localparam int         PORT_LSB = port_lsb(TX_TAG_W, PORTS);
    localparam logic [7:0] MAX_O    = 8'(MAX_OUTSTANDING);

    state_t                  r_state;
    logic [CL_PORTS-1:0]     r_grant;
    logic [CL_PORTS-1:0]     r_rr_ptr;
    logic [PORTS-1:0][7:0]   r_out;
    logic [PORTS-1:0]        r_full;
    logic [PORTS-1:0]        r_status_grant;
    logic                    r_drop;

    logic [PORTS-1:0]        w_req;
    logic [PORTS-1:0]        w_arb_gnt;
    logic [CL_PORTS-1:0]     w_arb_idx;
    logic                    w_arb_valid;
    logic                    w_xfer;
    logic                    w_last;
    logic [CL_PORTS-1:0]     w_cpl_port;
    logic                    w_cpl_ok;
    logic [PORTS-1:0]        w_cpl_sel;
    logic [PORTS-1:0]        w_inc;
    logic [PORTS-1:0]        w_dec;
    logic [PORTS-1:0][7:0]   w_out_nxt;
    logic [PORTS-1:0]        w_full_nxt;

    taxi_arb_rr #(.N(PORTS), .CL(CL_PORTS)) u_arb (
        .i_req   (w_req),
        .i_ptr   (r_rr_ptr),
        .o_gnt   (w_arb_gnt),
        .o_idx   (w_arb_idx),
        .o_valid (w_arb_valid)
    );

    assign w_xfer           = r_state == STATE_XFER;
    assign m_axis_tx_tdata  = s_axis_tx_tdata[r_grant];
    assign m_axis_tx_tkeep  = s_axis_tx_tkeep[r_grant];
    assign m_axis_tx_tlast  = s_axis_tx_tlast[r_grant];
    assign m_axis_tx_tuser  = s_axis_tx_tuser[r_grant];
    assign m_axis_tx_tid    = {r_grant, s_axis_tx_tid[r_grant]};
    assign m_axis_tx_tvalid = w_xfer & s_axis_tx_tvalid[r_grant];
    assign w_last           = m_axis_tx_tvalid & m_axis_tx_tready & m_axis_tx_tlast;

    assign w_cpl_port = s_axis_tx_cpl_tid[PORT_LSB +: CL_PORTS];
    assign w_cpl_ok   = int'(w_cpl_port) < PORTS;
    // completions for nonexistent ports are swallowed so the MAC never stalls on them
    assign s_axis_tx_cpl_tready = rst & (w_cpl_ok ? |(w_cpl_sel & m_axis_tx_cpl_tready) : 1'b1);

    always_comb begin
        w_req                = '0;
        w_inc                = '0;
        w_dec                = '0;
        w_cpl_sel            = '0;
        w_out_nxt            = r_out;
        w_full_nxt           = '0;
        s_axis_tx_tready     = '0;
        m_axis_tx_cpl_tvalid = '0;
        m_axis_tx_cpl_tdata  = '0;
        m_axis_tx_cpl_tid    = '0;
        for (int p = 0; p < PORTS; p++) begin
            w_req[p]                = s_axis_tx_tvalid[p] & cfg_port_enable[p] & (r_out[p] < MAX_O);
            s_axis_tx_tready[p]     = w_xfer & (int'(r_grant) == p) & m_axis_tx_tready;
            w_inc[p]                = w_last & (int'(r_grant) == p);
            w_cpl_sel[p]            = int'(w_cpl_port) == p;
            m_axis_tx_cpl_tvalid[p] = rst & s_axis_tx_cpl_tvalid & w_cpl_sel[p];
            m_axis_tx_cpl_tdata[p]  = s_axis_tx_cpl_tdata;
            m_axis_tx_cpl_tid[p]    = s_axis_tx_cpl_tid[IN_TAG_W-1:0];
            w_dec[p]                = m_axis_tx_cpl_tvalid[p] & m_axis_tx_cpl_tready[p];
            w_out_nxt[p]            = (w_inc[p] & ~w_dec[p]) ? r_out[p] + 8'd1 :
                                      (w_dec[p] & ~w_inc[p] & |r_out[p]) ? r_out[p] - 8'd1 : r_out[p];
            w_full_nxt[p]           = w_out_nxt[p] >= MAX_O;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state        <= STATE_IDLE;
            r_grant        <= '0;
            r_rr_ptr       <= '0;
            r_status_grant <= '0;
        end else if (r_state == STATE_IDLE) begin
            if (w_arb_valid) begin
                r_state        <= STATE_XFER;
                r_grant        <= w_arb_idx;
                r_status_grant <= w_arb_gnt;
            end
        end else if (w_last) begin
            r_state        <= STATE_IDLE;
            r_status_grant <= '0;
            r_rr_ptr       <= (int'(r_grant) == PORTS - 1) ? '0 : r_grant + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_out  <= '0;
            r_full <= '0;
            r_drop <= 1'b0;
        end else begin
            r_out  <= w_out_nxt;
            r_full <= w_full_nxt;
            r_drop <= s_axis_tx_cpl_tvalid & ~w_cpl_ok;
        end
    end

    assign status_grant            = r_status_grant;
    assign status_outstanding_full = r_full;
    assign stat_cpl_drop           = r_drop;

endmodule

// File: tb/tb_taxi_eth_tx_sched.sv
// tb_taxi_eth_tx_sched: directed checks of arbitration, tid rewrite, completion routing,
// outstanding limit, enable gating, invalid-port drop and reset behaviour.
module tb_taxi_eth_tx_sched;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [3:0][31:0] s_tdata;
    logic [3:0][3:0]  s_tkeep;
    logic [3:0]       s_tlast, s_tvalid, s_tready;
    logic [3:0][0:0]  s_tuser;
    logic [3:0][13:0] s_tid;
    logic [31:0]      m_tdata;
    logic [3:0]       m_tkeep;
    logic             m_tlast, m_tvalid, m_tready;
    logic [0:0]       m_tuser;
    logic [15:0]      m_tid;
    logic [95:0]      c_tdata;
    logic [15:0]      c_tid;
    logic             c_tvalid, c_tready;
    logic [3:0][95:0] mc_tdata;
    logic [3:0][13:0] mc_tid;
    logic [3:0]       mc_tvalid, mc_tready;
    logic [3:0]       cfg, grant, full;
    logic             drop;

    taxi_eth_tx_sched #(.PORTS(4), .MAX_OUTSTANDING(2)) dut (
        .clk(clk), .rst(rst),
        .s_axis_tx_tdata(s_tdata), .s_axis_tx_tkeep(s_tkeep), .s_axis_tx_tlast(s_tlast),
        .s_axis_tx_tuser(s_tuser), .s_axis_tx_tid(s_tid), .s_axis_tx_tvalid(s_tvalid),
        .s_axis_tx_tready(s_tready),
        .m_axis_tx_tdata(m_tdata), .m_axis_tx_tkeep(m_tkeep), .m_axis_tx_tlast(m_tlast),
        .m_axis_tx_tuser(m_tuser), .m_axis_tx_tid(m_tid), .m_axis_tx_tvalid(m_tvalid),
        .m_axis_tx_tready(m_tready),
        .s_axis_tx_cpl_tdata(c_tdata), .s_axis_tx_cpl_tid(c_tid),
        .s_axis_tx_cpl_tvalid(c_tvalid), .s_axis_tx_cpl_tready(c_tready),
        .m_axis_tx_cpl_tdata(mc_tdata), .m_axis_tx_cpl_tid(mc_tid),
        .m_axis_tx_cpl_tvalid(mc_tvalid), .m_axis_tx_cpl_tready(mc_tready),
        .cfg_port_enable(cfg), .status_grant(grant),
        .status_outstanding_full(full), .stat_cpl_drop(drop)
    );

    logic [2:0][31:0] b_s_tdata = '0;
    logic [2:0][3:0]  b_s_tkeep = '0;
    logic [2:0]       b_s_tlast = '0, b_s_tvalid = '0, b_s_tready;
    logic [2:0][0:0]  b_s_tuser = '0;
    logic [2:0][13:0] b_s_tid = '0;
    logic [31:0]      b_m_tdata;
    logic [3:0]       b_m_tkeep;
    logic             b_m_tlast, b_m_tvalid;
    logic [0:0]       b_m_tuser;
    logic [15:0]      b_m_tid;
    logic [95:0]      b_c_tdata = '0;
    logic [15:0]      b_c_tid = '0;
    logic             b_c_tvalid = 1'b0, b_c_tready;
    logic [2:0][95:0] b_mc_tdata;
    logic [2:0][13:0] b_mc_tid;
    logic [2:0]       b_mc_tvalid, b_mc_tready = '0;
    logic [2:0]       b_grant, b_full;
    logic             b_drop;

    taxi_eth_tx_sched #(.PORTS(3)) dut_b (
        .clk(clk), .rst(rst),
        .s_axis_tx_tdata(b_s_tdata), .s_axis_tx_tkeep(b_s_tkeep), .s_axis_tx_tlast(b_s_tlast),
        .s_axis_tx_tuser(b_s_tuser), .s_axis_tx_tid(b_s_tid), .s_axis_tx_tvalid(b_s_tvalid),
        .s_axis_tx_tready(b_s_tready),
        .m_axis_tx_tdata(b_m_tdata), .m_axis_tx_tkeep(b_m_tkeep), .m_axis_tx_tlast(b_m_tlast),
        .m_axis_tx_tuser(b_m_tuser), .m_axis_tx_tid(b_m_tid), .m_axis_tx_tvalid(b_m_tvalid),
        .m_axis_tx_tready(1'b1),
        .s_axis_tx_cpl_tdata(b_c_tdata), .s_axis_tx_cpl_tid(b_c_tid),
        .s_axis_tx_cpl_tvalid(b_c_tvalid), .s_axis_tx_cpl_tready(b_c_tready),
        .m_axis_tx_cpl_tdata(b_mc_tdata), .m_axis_tx_cpl_tid(b_mc_tid),
        .m_axis_tx_cpl_tvalid(b_mc_tvalid), .m_axis_tx_cpl_tready(b_mc_tready),
        .cfg_port_enable(3'b111), .status_grant(b_grant),
        .status_outstanding_full(b_full), .stat_cpl_drop(b_drop)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int m_beats = 0;
    int src_frames[4], src_len[4], src_beat[4];
    logic [13:0] src_tid[4];
    int glog[$];
    int tl_cyc[$];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic drive();
        for (int p = 0; p < 4; p++) begin
            s_tvalid[p] = src_frames[p] != 0;
            s_tlast[p]  = src_beat[p] == src_len[p] - 1;
            s_tdata[p]  = {16'(p), 16'(src_beat[p])};
            s_tkeep[p]  = 4'hF;
            s_tuser[p]  = 1'(p);
            s_tid[p]    = src_tid[p];
        end
    endtask

    task automatic tick();
        logic [3:0] fire;
        @(negedge clk);
        fire = s_tvalid & s_tready;
        if (m_tvalid && m_tready) begin
            m_beats++;
            if (m_tlast) begin
                glog.push_back(int'(m_tid[15:14]));
                tl_cyc.push_back(cyc);
            end
        end
        @(posedge clk);
        cyc++;
        #1;
        for (int p = 0; p < 4; p++) begin
            if (fire[p]) begin
                if (src_beat[p] == src_len[p] - 1) begin
                    src_beat[p] = 0;
                    src_frames[p]--;
                end else begin
                    src_beat[p]++;
                end
            end
        end
        drive();
    endtask

    task automatic clear_src();
        for (int p = 0; p < 4; p++) begin
            src_frames[p] = 0;
            src_beat[p]   = 0;
            src_len[p]    = 1;
            src_tid[p]    = '0;
        end
        drive();
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        cfg       = 4'hF;
        c_tvalid  = 1'b0;
        c_tid     = '0;
        c_tdata   = '0;
        mc_tready = '0;
        m_tready  = 1'b1;
        clear_src();
        repeat (2) tick();
        rst = 1'b1;
        glog.delete();
        tl_cyc.delete();
        m_beats = 0;
    endtask

    task automatic wait_done(input int p, input int budget);
        for (int k = 0; k < budget && src_frames[p] != 0; k++) tick();
    endtask

    initial begin
        m_tready  = 1'b1;
        cfg       = 4'hF;
        clear_src();
        c_tvalid  = 1'b1;
        c_tid     = 16'h0000;
        c_tdata   = 96'h55;
        mc_tready = 4'hF;
        repeat (2) tick();
        chk("rst_grant", 128'(grant), 128'(0));
        chk("rst_full", 128'(full), 128'(0));
        chk("rst_drop", 128'(drop), 128'(0));
        chk("rst_m_tvalid", 128'(m_tvalid), 128'(0));
        chk("rst_s_tready", 128'(s_tready), 128'(0));
        chk("rst_cpl_tvalid", 128'(mc_tvalid), 128'(0));
        chk("rst_cpl_tready", 128'(c_tready), 128'(0));

        // single 16-beat frame from port 2
        do_reset();
        src_len[2] = 16; src_tid[2] = 14'h5; src_frames[2] = 1;
        drive();
        #1;
        chk("idle_m_tvalid", 128'(m_tvalid), 128'(0));
        chk("idle_s_tready", 128'(s_tready), 128'(0));
        tick();
        chk("t1_grant", 128'(grant), 128'(4'b0100));
        chk("t1_m_tvalid", 128'(m_tvalid), 128'(1));
        chk("t1_s_tready", 128'(s_tready), 128'(4'b0100));
        chk("t1_tid", 128'(m_tid), 128'(16'h8005));
        chk("t1_tdata", 128'(m_tdata), 128'(32'h0002_0000));
        chk("t1_tkeep", 128'(m_tkeep), 128'(4'hF));
        wait_done(2, 40);
        chk("t1_done", 128'(src_frames[2]), 128'(0));
        chk("t1_beats", 128'(m_beats), 128'(16));
        chk("t1_grant_idle", 128'(grant), 128'(0));
        chk("t1_full", 128'(full), 128'(0));
        c_tvalid = 1'b1; c_tid = 16'h8005; c_tdata = 96'h1234; mc_tready = 4'b0100;
        #1;
        chk("t1_cpl_tvalid", 128'(mc_tvalid), 128'(4'b0100));
        chk("t1_cpl_tid", 128'(mc_tid[2]), 128'(14'h5));
        chk("t1_cpl_tdata", 128'(mc_tdata[2]), 128'(96'h1234));
        chk("t1_cpl_tready", 128'(c_tready), 128'(1));
        tick();
        c_tvalid = 1'b0; mc_tready = '0;
        src_len[2] = 1; src_frames[2] = 1;
        drive();
        wait_done(2, 10);
        chk("t1_after_cpl_full", 128'(full), 128'(0));

        // fairness: port 0 has two frames, others one
        do_reset();
        for (int p = 0; p < 4; p++) src_len[p] = 2;
        src_frames[0] = 2; src_frames[1] = 1; src_frames[2] = 1; src_frames[3] = 1;
        drive();
        for (int k = 0; k < 60 && glog.size() < 5; k++) tick();
        chk("fair_count", 128'(glog.size()), 128'(5));
        chk("fair_0", 128'(glog.size() > 0 ? glog[0] : -1), 128'(0));
        chk("fair_1", 128'(glog.size() > 1 ? glog[1] : -1), 128'(1));
        chk("fair_2", 128'(glog.size() > 2 ? glog[2] : -1), 128'(2));
        chk("fair_3", 128'(glog.size() > 3 ? glog[3] : -1), 128'(3));
        chk("fair_4", 128'(glog.size() > 4 ? glog[4] : -1), 128'(0));
        for (int i = 1; i < 5; i++)
            chk($sformatf("fair_gap%0d", i), 128'(tl_cyc.size() > i ? tl_cyc[i] - tl_cyc[i-1] : -1), 128'(3));
        chk("fair_full", 128'(full), 128'(4'b0001));

        // outstanding limit of 2 on port 1
        do_reset();
        src_frames[1] = 3;
        drive();
        repeat (12) tick();
        chk("lim_left", 128'(src_frames[1]), 128'(1));
        chk("lim_full", 128'(full), 128'(4'b0010));
        chk("lim_frames", 128'(glog.size()), 128'(2));
        c_tvalid = 1'b1; c_tid = 16'h4000; mc_tready = 4'b0010;
        #1;
        chk("lim_cpl_tready", 128'(c_tready), 128'(1));
        tick();
        c_tvalid = 1'b0; mc_tready = '0;
        wait_done(1, 6);
        chk("lim_third_sent", 128'(src_frames[1]), 128'(0));
        chk("lim_full_again", 128'(full), 128'(4'b0010));
        chk("lim_no_drop", 128'(drop), 128'(0));

        // tlast and completion on port 0 in the same cycle
        do_reset();
        mc_tready = 4'b0001;
        src_frames[0] = 1;
        drive();
        wait_done(0, 10);
        src_len[0] = 3; src_frames[0] = 1;
        drive();
        for (int k = 0; k < 20 && src_frames[0] != 0; k++) begin
            c_tid    = 16'h0000;
            c_tvalid = s_tready[0] & s_tlast[0];
            tick();
        end
        c_tvalid = 1'b0;
        chk("sim_full", 128'(full), 128'(0));
        src_len[0] = 1; src_frames[0] = 1;
        drive();
        wait_done(0, 10);
        chk("sim_full_after", 128'(full), 128'(4'b0001));

        // completion while counter is already 0
        do_reset();
        mc_tready = 4'b0100; c_tid = 16'h8000; c_tvalid = 1'b1;
        tick();
        c_tvalid = 1'b0; mc_tready = '0;
        src_frames[2] = 2;
        drive();
        wait_done(2, 20);
        chk("sat_sent", 128'(src_frames[2]), 128'(0));
        chk("sat_full", 128'(full), 128'(4'b0100));

        // port 3 disabled mid-frame
        do_reset();
        src_len[3] = 4; src_frames[3] = 2;
        drive();
        for (int k = 0; k < 30 && src_frames[3] == 2; k++) begin
            if (src_beat[3] == 1) cfg[3] = 1'b0;
            tick();
        end
        chk("en_frame_done", 128'(src_frames[3]), 128'(1));
        chk("en_beats", 128'(m_beats), 128'(4));
        repeat (8) tick();
        chk("en_no_regrant", 128'(src_frames[3]), 128'(1));
        chk("en_m_tvalid", 128'(m_tvalid), 128'(0));

        // invalid port field on the 3-port instance
        b_c_tid = 16'hC000; b_c_tvalid = 1'b1;
        #1;
        chk("drop_tready", 128'(b_c_tready), 128'(1));
        chk("drop_no_route", 128'(b_mc_tvalid), 128'(0));
        tick();
        b_c_tvalid = 1'b0;
        chk("drop_pulse", 128'(b_drop), 128'(1));
        tick();
        chk("drop_pulse_end", 128'(b_drop), 128'(0));

        // reset during beat 5 of a port-1 frame
        do_reset();
        src_frames[2] = 1;
        drive();
        wait_done(2, 10);
        src_len[1] = 10; src_frames[1] = 1;
        drive();
        for (int k = 0; k < 30 && src_beat[1] != 5; k++) tick();
        chk("rst_mid_reach", 128'(src_beat[1]), 128'(5));
        rst = 1'b0;
        tick();
        chk("rstm_m_tvalid", 128'(m_tvalid), 128'(0));
        chk("rstm_s_tready", 128'(s_tready), 128'(0));
        chk("rstm_grant", 128'(grant), 128'(0));
        chk("rstm_full", 128'(full), 128'(0));
        rst = 1'b1;
        clear_src();
        glog.delete();
        src_frames[0] = 1; src_frames[1] = 1; src_frames[3] = 1;
        drive();
        for (int k = 0; k < 10 && glog.size() == 0; k++) tick();
        chk("rstm_first_cnt", 128'(glog.size() > 0), 128'(1));
        chk("rstm_first_port", 128'(glog.size() > 0 ? glog[0] : -1), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
